// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: byte-masked word writes, registered full-word reads,
// optional wait states reported through a stall request.
module data_sram_responder #(
  parameter int AW          = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_for_mem
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  localparam logic [3:0] N        = 4'(WAIT_CYCLES);
  localparam bit         HAS_WAIT = (WAIT_CYCLES != 0);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q;
  logic [3:0]      wen_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [2**AW];

  logic [AW-1:0]   in_addr;
  logic            latch;
  logic            commit;
  logic [AW-1:0]   c_addr;
  logic [3:0]      c_wen;
  logic [31:0]     c_wdata;
  logic            stall;

  // Byte offset and high address bits alias onto the same word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_sram_addr[31:AW+2], data_sram_addr[1:0]};

  assign in_addr = data_sram_addr[AW+1:2];
  assign latch   = !rst && HAS_WAIT && (state_q == IDLE) && data_sram_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (HAS_WAIT && data_sram_en) begin
          state_d = WAIT;
          cnt_d   = 4'd1;
        end
      end
      WAIT: begin
        if (cnt_q == N) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_comb begin
    stall   = 1'b0;
    commit  = 1'b0;
    c_addr  = in_addr;
    c_wen   = data_sram_wen;
    c_wdata = data_sram_wdata;
    unique case (state_q)
      IDLE: begin
        stall  = HAS_WAIT && data_sram_en;
        commit = !HAS_WAIT && data_sram_en;
      end
      WAIT: begin
        stall   = (cnt_q != N);
        commit  = (cnt_q == N);
        c_addr  = addr_q;
        c_wen   = wen_q;
        c_wdata = wdata_q;
      end
    endcase
    if (rst) begin
      stall  = 1'b0;
      commit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wen_q   <= 4'd0;
      wdata_q <= 32'd0;
    end else if (latch) begin
      addr_q  <= in_addr;
      wen_q   <= data_sram_wen;
      wdata_q <= data_sram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (c_wen[i]) mem[c_addr][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  // Read and write never commit on the same edge, so no bypass is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'd0;
    end else if (commit && (c_wen == 4'd0)) begin
      rdata_q <= mem[c_addr];
    end
  end

  assign data_sram_rdata  = rdata_q;
  assign stallreq_for_mem = stall;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: a zero-wait and a 3-wait instance checked
// against a transaction-level memory model every cycle.
module tb_data_sram_responder;

  localparam int AW = 12;
  localparam int NW = 4096;
  localparam int N3 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en   [2];
  logic [3:0]  wen  [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic [31:0] rd   [2];
  logic        st   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.AW(AW), .WAIT_CYCLES(0)) u0 (
    .clk              (clk),
    .rst              (rst),
    .data_sram_en     (en[0]),
    .data_sram_wen    (wen[0]),
    .data_sram_addr   (addr[0]),
    .data_sram_wdata  (wd[0]),
    .data_sram_rdata  (rd[0]),
    .stallreq_for_mem (st[0])
  );

  data_sram_responder #(.AW(AW), .WAIT_CYCLES(N3)) u3 (
    .clk              (clk),
    .rst              (rst),
    .data_sram_en     (en[1]),
    .data_sram_wen    (wen[1]),
    .data_sram_addr   (addr[1]),
    .data_sram_wdata  (wd[1]),
    .data_sram_rdata  (rd[1]),
    .stallreq_for_mem (st[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: memory contents plus, per instance, the cycle on which a
  // pending access is due to commit.
  logic [31:0] mm   [2][NW];
  bit          mk   [2][NW];
  logic [31:0] er   [2];
  bit          ek   [2];
  bit          pend [2];
  longint      due  [2];
  int          pidx [2];
  logic [3:0]  pwen [2];
  logic [31:0] pwd  [2];
  longint      cyc = 0;
  bit          armed = 0;

  function automatic int nwait(input int k);
    return (k == 0) ? 0 : N3;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % NW);
  endfunction

  function automatic void mcommit(input int k, input int idx,
                                  input logic [3:0] w, input logic [31:0] d);
    if (w == 4'h0) begin
      er[k] = mm[k][idx];
      ek[k] = mk[k][idx];
    end else begin
      for (int b = 0; b < 4; b++)
        if (w[b]) mm[k][idx][8*b +: 8] = d[8*b +: 8];
      if (w == 4'hF) mk[k][idx] = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pend[k] = 1'b0;
        er[k]   = 32'd0;
        ek[k]   = 1'b1;
      end else if (pend[k]) begin
        if (cyc == due[k]) begin
          mcommit(k, pidx[k], pwen[k], pwd[k]);
          pend[k] = 1'b0;
        end
      end else if (en[k]) begin
        if (nwait(k) == 0) begin
          mcommit(k, widx(addr[k]), wen[k], wd[k]);
        end else begin
          pend[k] = 1'b1;
          due[k]  = cyc + nwait(k);
          pidx[k] = widx(addr[k]);
          pwen[k] = wen[k];
          pwd[k]  = wd[k];
        end
      end
    end
    if (rst) armed = 1'b1;
    cyc++;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        logic exp_st;
        if (rst)          exp_st = 1'b0;
        else if (pend[k]) exp_st = (cyc < due[k]);
        else              exp_st = (nwait(k) > 0) && en[k];
        chk($sformatf("stall%0d", k), {31'd0, st[k]}, {31'd0, exp_st});
        if (ek[k]) chk($sformatf("rdata%0d", k), rd[k], er[k]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc0(input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d);
    en[0]   = 1'b1;
    wen[0]  = w;
    addr[0] = a;
    wd[0]   = d;
    step();
    en[0] = 1'b0;
  endtask

  task automatic op3(input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d);
    en[1]   = 1'b1;
    wen[1]  = w;
    addr[1] = a;
    wd[1]   = d;
    #1 chk("op3_stall_T", {31'd0, st[1]}, 32'd1);
    step();
    for (int i = 1; i <= N3; i++) begin
      addr[1] = $urandom;
      wd[1]   = $urandom;
      wen[1]  = 4'($urandom);
      #1 chk("op3_stall_wait", {31'd0, st[1]}, (i < N3) ? 32'd1 : 32'd0);
      step();
    end
    en[1] = 1'b0;
  endtask

  function automatic logic [31:0] raddr();
    logic [31:0] a;
    a = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2);
    return a;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      en[k]   = 1'b1;
      wen[k]  = 4'hF;
      addr[k] = 32'h0C;
      wd[k]   = 32'hFFFF_FFFF;
    end
    rst = 1'b1;
    #1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_rdata0", rd[0], 32'd0);
      chk("rst_rdata3", rd[1], 32'd0);
      chk("rst_stall3", {31'd0, st[1]}, 32'd0);
    end
    en[0] = 1'b0;
    en[1] = 1'b0;
    rst   = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      acc0(4'hF, 32'(i) << 2, 32'h1000_0000 + 32'(i) * 32'h0101_0101);
      op3(4'hF, 32'(i) << 2, 32'h1000_0000 + 32'(i) * 32'h0101_0101);
    end
    chk("rdata3_held_over_writes", rd[1], 32'd0);

    acc0(4'hF, 32'h10, 32'hDEAD_BEEF);
    acc0(4'h0, 32'h10, 32'd0);
    chk("full_word", rd[0], 32'hDEAD_BEEF);

    acc0(4'hF, 32'h14, 32'h1122_3344);
    acc0(4'b0100, 32'h14, 32'h00AA_0000);
    acc0(4'h0, 32'h14, 32'd0);
    chk("lane2", rd[0], 32'h11AA_3344);
    acc0(4'b0011, 32'h14, 32'h0000_BEEF);
    chk("rdata_held", rd[0], 32'h11AA_3344);
    acc0(4'h0, 32'h14, 32'd0);
    chk("lanes01", rd[0], 32'h11AA_BEEF);

    acc0(4'hF, 32'h0000_4008, 32'hCAFE_F00D);
    acc0(4'h0, 32'h0000_000B, 32'd0);
    chk("alias", rd[0], 32'hCAFE_F00D);

    rst     = 1'b1;
    en[0]   = 1'b1;
    wen[0]  = 4'hF;
    addr[0] = 32'h0C;
    wd[0]   = 32'd0;
    step();
    step();
    rst   = 1'b0;
    en[0] = 1'b0;
    acc0(4'h0, 32'h0C, 32'd0);
    chk("rst_no_write", rd[0], 32'h1303_0303);

    op3(4'hF, 32'h10, 32'hDEAD_BEEF);
    op3(4'h0, 32'h10, 32'd0);
    chk("wait_read", rd[1], 32'hDEAD_BEEF);

    en[1]   = 1'b1;
    wen[1]  = 4'hF;
    addr[1] = 32'h18;
    wd[1]   = 32'h1234_5678;
    step();
    addr[1] = 32'h0;
    step();
    rst   = 1'b1;
    en[1] = 1'b0;
    #1 chk("midop_rst_stall", {31'd0, st[1]}, 32'd0);
    step();
    rst = 1'b0;
    #1 chk("midop_after_stall", {31'd0, st[1]}, 32'd0);
    chk("midop_after_rdata", rd[1], 32'd0);
    step();
    op3(4'h0, 32'h18, 32'd0);
    chk("midop_unchanged", rd[1], 32'h1606_0606);

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        en[k]   = 1'($urandom_range(0, 1));
        wen[k]  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        addr[k] = raddr();
        wd[k]   = $urandom;
      end
      step();
    end
    rst   = 1'b0;
    en[0] = 1'b0;
    en[1] = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
